// File: rtl/dram_rd_pkg.sv
// Shared definitions for the DRAM0 read-data capture path.
// Holds the default geometry of the read queue and the line record
// (two beats of data plus their ECC) that the queue carries.
package dram_rd_pkg;

  localparam int DRAM_DEPTH  = 4;
  localparam int DRAM_BEAT_W = 256;
  localparam int DRAM_ECC_W  = 32;

  // One queued line: data = {beat1, beat0}, ecc = {ecc1, ecc0}.
  // The packed layout {data, ecc} is the bit order used on the queue.
  typedef struct packed {
    logic [2*DRAM_BEAT_W-1:0] data;
    logic [2*DRAM_ECC_W-1:0]  ecc;
  } line_t;

endpackage

// File: rtl/dram0_rdq_fifo.sv
// Line queue for the DRAM0 read-data capture path.
// Ports:
//   clk, arst       - clock, asynchronous active-high reset
//   push, push_line - offer a line; dropped when full unless a pop happens too
//   pop             - remove head line (ignored while empty)
//   flush           - synchronous clear of count and pointers, beats push/pop
//   head            - line at the read pointer (valid when cnt > 0)
//   cnt, full       - number of lines held, cnt == DEPTH
module dram0_rdq_fifo
  import dram_rd_pkg::*;
#(
  parameter int DEPTH = DRAM_DEPTH,
  parameter int W     = $bits(line_t),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             push,
  input  logic [W-1:0]     push_line,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     head,
  output logic [PTR_W:0]   cnt,
  output logic             full
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && (cnt != '0) && !flush;
  // A full queue still takes a line when the head leaves on the same edge.
  assign do_push = push && !flush && (!full || do_pop);

  // Head is read straight from the array so a line pushed into an empty
  // queue is visible the cycle after the edge that wrote it.
  assign head = mem[rd_ptr];

  // Storage carries no reset; its contents only matter below cnt.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_line;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dram0_rdata_capture.sv
// DRAM0 read-data capture: pairs incoming read beats into lines and queues
// them for the consumer.
// Ports:
//   clk, arst                      - clock, asynchronous active-high reset
//   io_dram_data_valid_buf         - valid read beat from the pad repeater
//   io_dram_data_in_buf / _ecc_    - beat data and ECC
//   que_rd_ready                   - consumer takes the head line
//   que_flush                      - discard all captured state
//   dram_rd_valid/_data/_ecc       - head line, data {beat1,beat0}, ecc {ecc1,ecc0}
//   dram_rd_cnt                    - lines held
//   dram_rd_ovf                    - sticky: a line was dropped on a full queue
module dram0_rdata_capture
  import dram_rd_pkg::*;
#(
  parameter int DEPTH  = DRAM_DEPTH,
  parameter int BEAT_W = DRAM_BEAT_W,
  parameter int ECC_W  = DRAM_ECC_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 io_dram_data_valid_buf,
  input  logic [BEAT_W-1:0]    io_dram_data_in_buf,
  input  logic [ECC_W-1:0]     io_dram_ecc_in_buf,
  input  logic                 que_rd_ready,
  input  logic                 que_flush,
  output logic                 dram_rd_valid,
  output logic [2*BEAT_W-1:0]  dram_rd_data,
  output logic [2*ECC_W-1:0]   dram_rd_ecc,
  output logic [CNT_W-1:0]     dram_rd_cnt,
  output logic                 dram_rd_ovf
);

  localparam int LINE_W = 2*BEAT_W + 2*ECC_W;

  logic              phase;
  logic [BEAT_W-1:0] beat0_data;
  logic [ECC_W-1:0]  beat0_ecc;
  logic              push;
  logic              full;
  logic [LINE_W-1:0] push_line;
  logic [LINE_W-1:0] head;

  // Second beat of a pair completes a line; a flush kills the beat it sees.
  assign push      = io_dram_data_valid_buf && phase && !que_flush;
  assign push_line = {io_dram_data_in_buf, beat0_data, io_dram_ecc_in_buf, beat0_ecc};

  // Beat0 holding register is not reset; phase decides whether it is live.
  always_ff @(posedge clk) begin
    if (io_dram_data_valid_buf && !phase) begin
      beat0_data <= io_dram_data_in_buf;
      beat0_ecc  <= io_dram_ecc_in_buf;
    end
  end

  // Phase still toggles when the completed line is dropped on overflow.
  // Full implies the head is valid, so que_rd_ready alone means a pop.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      phase       <= 1'b0;
      dram_rd_ovf <= 1'b0;
    end else if (que_flush) begin
      phase       <= 1'b0;
      dram_rd_ovf <= 1'b0;
    end else begin
      if (io_dram_data_valid_buf) phase <= !phase;
      if (push && full && !que_rd_ready) dram_rd_ovf <= 1'b1;
    end
  end

  dram0_rdq_fifo #(
    .DEPTH (DEPTH),
    .W     (LINE_W)
  ) u_fifo (
    .clk       (clk),
    .arst      (arst),
    .push      (push),
    .push_line (push_line),
    .pop       (que_rd_ready),
    .flush     (que_flush),
    .head      (head),
    .cnt       (dram_rd_cnt),
    .full      (full)
  );

  assign dram_rd_valid = (dram_rd_cnt != '0);
  assign dram_rd_data  = head[LINE_W-1:2*ECC_W];
  assign dram_rd_ecc   = head[2*ECC_W-1:0];

endmodule

// File: tb/tb_dram0_rdata_capture.sv
module tb_dram0_rdata_capture;
  import dram_rd_pkg::*;

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic         valid = 1'b0;
  logic [255:0] din = '0;
  logic [31:0]  ecc = '0;
  logic         ready = 1'b0;
  logic         flush = 1'b0;
  logic         rd_valid;
  logic [511:0] rd_data;
  logic [63:0]  rd_ecc;
  logic [2:0]   rd_cnt;
  logic         rd_ovf;

  int total = 0;
  int bad = 0;
  int max_cnt = 0;

  dram0_rdata_capture dut (
    .clk                    (clk),
    .arst                   (arst),
    .io_dram_data_valid_buf (valid),
    .io_dram_data_in_buf    (din),
    .io_dram_ecc_in_buf     (ecc),
    .que_rd_ready           (ready),
    .que_flush              (flush),
    .dram_rd_valid          (rd_valid),
    .dram_rd_data           (rd_data),
    .dram_rd_ecc            (rd_ecc),
    .dram_rd_cnt            (rd_cnt),
    .dram_rd_ovf            (rd_ovf)
  );

  always #5 clk = !clk;

  task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] bd(input logic [31:0] id);
    return {8{id}};
  endfunction

  // ---------------- behavioural model ----------------
  line_t        m_q[$];
  bit           m_phase = 0;
  bit           m_ovf = 0;
  logic [255:0] m_b0;
  logic [31:0]  m_e0;
  line_t        m_nl;
  bit           m_have;
  bit           m_pop;
  int           m_sz;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_q.delete();
      m_phase = 0;
      m_ovf = 0;
    end else if (flush) begin
      m_q.delete();
      m_phase = 0;
      m_ovf = 0;
    end else begin
      m_sz = m_q.size();
      m_pop = (m_sz > 0) && ready;
      m_have = 0;
      if (valid) begin
        if (!m_phase) begin
          m_b0 = din;
          m_e0 = ecc;
        end else begin
          m_nl.data = {din, m_b0};
          m_nl.ecc = {ecc, m_e0};
          m_have = 1;
        end
        m_phase = !m_phase;
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_have) begin
        if (m_sz == 4 && !m_pop) m_ovf = 1;
        else m_q.push_back(m_nl);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!arst) begin
      chk("cnt", 576'(rd_cnt), 576'(m_q.size()));
      chk("valid", 576'(rd_valid), 576'(m_q.size() > 0));
      chk("ovf", 576'(rd_ovf), 576'(m_ovf));
      if (m_q.size() > 0) begin
        chk("data", 576'(rd_data), 576'(m_q[0].data));
        chk("ecc", 576'(rd_ecc), 576'(m_q[0].ecc));
      end
      if (int'(rd_cnt) > max_cnt) max_cnt = int'(rd_cnt);
    end
  end

  task automatic step(input logic v, input logic [31:0] id, input logic [31:0] e,
                      input logic rdy, input logic fl);
    valid = v;
    din = bd(id);
    ecc = e;
    ready = rdy;
    flush = fl;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 576'(rd_valid), 576'(0));
    chk("rst_cnt", 576'(rd_cnt), 576'(0));
    chk("rst_ovf", 576'(rd_ovf), 576'(0));
    arst = 1'b0;

    // back-to-back beats
    step(1, 32'hA0, 32'h11, 1, 0);
    $display("beat A0 cnt=%0d", rd_cnt);
    step(1, 32'hA1, 32'h22, 1, 0);
    $display("beat A1 cnt=%0d valid=%0d", rd_cnt, rd_valid);
    chk("b2b_valid", 576'(rd_valid), 576'(1));
    chk("b2b_cnt", 576'(rd_cnt), 576'(1));
    chk("b2b_data", 576'(rd_data), 576'({bd(32'hA1), bd(32'hA0)}));
    chk("b2b_ecc", 576'(rd_ecc), 576'(64'h0000_0022_0000_0011));
    step(0, 0, 0, 1, 0);
    chk("b2b_pop", 576'(rd_cnt), 576'(0));

    // fill to full, then overflow
    for (int i = 1; i <= 8; i++) step(1, i, i, 0, 0);
    $display("fill cnt=%0d ovf=%0d", rd_cnt, rd_ovf);
    chk("full_cnt", 576'(rd_cnt), 576'(4));
    chk("full_ovf", 576'(rd_ovf), 576'(0));
    step(1, 9, 9, 0, 0);
    step(1, 10, 10, 0, 0);
    $display("overflow cnt=%0d ovf=%0d", rd_cnt, rd_ovf);
    chk("ovf_cnt", 576'(rd_cnt), 576'(4));
    chk("ovf_set", 576'(rd_ovf), 576'(1));
    for (int k = 0; k < 4; k++) begin
      chk("order", 576'(rd_data), 576'({bd(2*k+2), bd(2*k+1)}));
      step(0, 0, 0, 1, 0);
      $display("pop %0d cnt=%0d", k, rd_cnt);
    end
    chk("ovf_sticky", 576'(rd_ovf), 576'(1));
    step(0, 0, 0, 0, 1);
    chk("flush_ovf", 576'(rd_ovf), 576'(0));

    // push and pop on the same edge while full
    for (int i = 21; i <= 28; i++) step(1, i, i, 0, 0);
    step(1, 29, 29, 0, 0);
    step(1, 30, 30, 1, 0);
    $display("full push/pop cnt=%0d ovf=%0d", rd_cnt, rd_ovf);
    chk("pp_cnt", 576'(rd_cnt), 576'(4));
    chk("pp_ovf", 576'(rd_ovf), 576'(0));
    chk("pp_head", 576'(rd_data), 576'({bd(24), bd(23)}));
    repeat (3) step(0, 0, 0, 1, 0);
    chk("pp_tail", 576'(rd_data), 576'({bd(30), bd(29)}));
    step(0, 0, 0, 1, 0);

    // flush in the middle of a line
    step(1, 50, 50, 0, 0);
    step(1, 51, 51, 0, 1);
    chk("fl_cnt", 576'(rd_cnt), 576'(0));
    step(1, 52, 52, 0, 0);
    chk("fl_phase", 576'(rd_cnt), 576'(0));
    step(1, 53, 53, 0, 0);
    $display("flush mid-line cnt=%0d", rd_cnt);
    chk("fl_line", 576'(rd_data), 576'({bd(53), bd(52)}));
    step(0, 0, 0, 1, 0);

    // async reset with cnt=3, ovf=1, and a half line pending
    for (int i = 61; i <= 70; i++) step(1, i, i, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 71, 71, 0, 0);
    chk("pre_rst_cnt", 576'(rd_cnt), 576'(3));
    chk("pre_rst_ovf", 576'(rd_ovf), 576'(1));
    @(posedge clk);
    #2 arst = 1'b1;
    #1;
    $display("async reset cnt=%0d ovf=%0d valid=%0d", rd_cnt, rd_ovf, rd_valid);
    chk("arst_valid", 576'(rd_valid), 576'(0));
    chk("arst_cnt", 576'(rd_cnt), 576'(0));
    chk("arst_ovf", 576'(rd_ovf), 576'(0));
    @(negedge clk);
    arst = 1'b0;
    step(1, 80, 80, 0, 0);
    step(1, 81, 81, 0, 0);
    chk("rst_beat0", 576'(rd_data), 576'({bd(81), bd(80)}));
    step(0, 0, 0, 1, 0);

    // streaming with random ready: pointer wrap
    for (int i = 0; i < 40; i++) begin
      step(1, 100 + i, 32'(i), 1'($urandom_range(0, 1)), 0);
      $display("stream beat %0d cnt=%0d", i, rd_cnt);
    end
    repeat (12) step(0, 0, 0, 1, 0);
    chk("drain_cnt", 576'(rd_cnt), 576'(0));
    chk("max_cnt_le_4", 576'(max_cnt <= 4), 576'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
